// File: rtl/dmem_access_sequencer.sv
// rtl/dmem_access_sequencer.sv - round-robin r0/r1 sequencer splitting ops into dmem word beats
// Optional macro DMEM_SEQ_BOUNDS_CHECK_EN rejects out-of-region spans and ROM writes.
module dmem_access_sequencer #(
   parameter int S         = 32,
   parameter int V         = 192,
   parameter int ROM_BASE  = 1000,
   parameter int ROM_DEPTH = 150000,
   parameter int RAM_BASE  = 151000,
   parameter int RAM_DEPTH = 150000
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         r0_valid,
   output logic         r0_ready,
   input  logic         r0_we,
   input  logic         r0_vec,
   input  logic [S-1:0] r0_addr,
   input  logic [V-1:0] r0_wd,
   input  logic         r1_valid,
   output logic         r1_ready,
   input  logic         r1_we,
   input  logic         r1_vec,
   input  logic [S-1:0] r1_addr,
   input  logic [V-1:0] r1_wd,
   output logic         rsp_valid,
   output logic         rsp_id,
   output logic [V-1:0] rsp_rdata,
   output logic         rsp_err,
   output logic         mem_en,
   output logic         mem_we,
   output logic         mem_sel,
   output logic [S-1:0] mem_addr,
   output logic [S-1:0] mem_wd,
   input  logic [S-1:0] mem_rd,
   output logic         busy
);

   localparam int LANES = V / S;
   localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;
   localparam logic [S-1:0]  ROM_LO    = S'(ROM_BASE);
   localparam logic [S-1:0]  RAM_LO    = S'(RAM_BASE);
   localparam logic [CW-1:0] LAST_LANE = CW'(LANES - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
   state_t state, state_nx;

   logic          rr_last, id_r, we_r, vec_r, sel_r, err_r, rd_pend;
   logic [S-1:0]  addr_r, base_r;
   logic [V-1:0]  wd_r, rdata_r;
   logic [CW-1:0] cnt, rd_lane, last_cnt;

   logic          g, accept, s_we, s_vec, s_sel, s_err;
   logic [S-1:0]  s_addr;
   logic [V-1:0]  s_wd;

`ifdef DMEM_SEQ_BOUNDS_CHECK_EN
   localparam logic [S-1:0] ROM_HI = S'(ROM_BASE + ROM_DEPTH);
   localparam logic [S-1:0] RAM_HI = S'(RAM_BASE + RAM_DEPTH);
   logic [S-1:0] s_end;
   logic         rom_ok, ram_ok;
`endif

   // Tie goes to the requester that did not win last time.
   always_comb begin
      g      = (r0_valid && r1_valid) ? ~rr_last : ~r0_valid;
      accept = (state == IDLE) && (r0_valid || r1_valid) && !rst;
      s_we   = g ? r1_we   : r0_we;
      s_vec  = g ? r1_vec  : r0_vec;
      s_addr = g ? r1_addr : r0_addr;
      s_wd   = g ? r1_wd   : r0_wd;
      s_sel  = (s_addr >= RAM_LO);
`ifdef DMEM_SEQ_BOUNDS_CHECK_EN
      s_end  = s_addr + (s_vec ? S'(LANES - 1) : '0);
      rom_ok = (s_addr >= ROM_LO) && (s_end < ROM_HI) && (s_end >= s_addr);
      ram_ok = (s_addr >= RAM_LO) && (s_end < RAM_HI) && (s_end >= s_addr);
      s_err  = !(rom_ok || ram_ok) || (rom_ok && s_we);
`else
      s_err  = 1'b0;
`endif
   end

   assign r0_ready = accept && !g;
   assign r1_ready = accept && g;
   assign last_cnt = vec_r ? LAST_LANE : '0;

   always_comb begin
      state_nx  = state;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_sel   = 1'b0;
      mem_addr  = '0;
      mem_wd    = '0;
      rsp_valid = 1'b0;
      rsp_id    = 1'b0;
      rsp_err   = 1'b0;
      rsp_rdata = '0;
      case (state)
         IDLE:  if (accept) state_nx = s_err ? RESP : ISSUE;
         ISSUE: begin
            mem_en   = 1'b1;
            mem_we   = we_r;
            mem_sel  = sel_r;
            mem_addr = addr_r + S'(cnt) - base_r;
            mem_wd   = wd_r[S*int'(cnt) +: S];
            if (cnt == last_cnt) state_nx = WAIT;
         end
         WAIT:  state_nx = RESP;
         RESP: begin
            rsp_valid = 1'b1;
            rsp_id    = id_r;
            rsp_err   = err_r;
            rsp_rdata = rdata_r;
            state_nx  = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         rr_last <= 1'b1;
         id_r    <= 1'b0;
         we_r    <= 1'b0;
         vec_r   <= 1'b0;
         sel_r   <= 1'b0;
         err_r   <= 1'b0;
         addr_r  <= '0;
         base_r  <= '0;
         wd_r    <= '0;
         rdata_r <= '0;
         cnt     <= '0;
         rd_pend <= 1'b0;
         rd_lane <= '0;
      end else begin
         state   <= state_nx;
         // Bank read data arrives one cycle after its beat.
         rd_pend <= (state == ISSUE) && !we_r;
         rd_lane <= cnt;
         if (rd_pend) rdata_r[S*int'(rd_lane) +: S] <= mem_rd;
         if (state == ISSUE) cnt <= cnt + 1'b1;
         if (accept) begin
            rr_last <= g;
            id_r    <= g;
            we_r    <= s_we;
            vec_r   <= s_vec;
            sel_r   <= s_sel;
            err_r   <= s_err;
            addr_r  <= s_addr;
            base_r  <= s_sel ? RAM_LO : ROM_LO;
            wd_r    <= s_wd;
            rdata_r <= '0;
            cnt     <= '0;
         end
      end
   end

endmodule
